freq_generator: RTL and testbench

FREQ_GENERATOR -- requirements
Module: freq_generator

---
 rtl/freq_generator_pkg.sv | 11 +
 rtl/freq_generator_if.sv | 23 ++
 rtl/freq_generator.sv | 151 +++++++++++++++
 tb/tb_freq_generator.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/freq_generator_pkg.sv
// Shared types and defaults for the programmable square/PWM frequency generator.
package freq_generator_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int MIN_PERIOD_DEF = 2;

endpackage

// File: rtl/freq_generator_if.sv
// Run request, config handshake and generated-wave outputs of freq_generator.
interface freq_generator_if #(
    parameter int CNTR_SIZE = 10
);
    logic                 en;
    logic [CNTR_SIZE-1:0] cfg_period;
    logic [CNTR_SIZE-1:0] cfg_high;
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic                 freq_out;
    logic                 tick;
    logic                 active;

    modport master (
        output en, cfg_period, cfg_high, cfg_valid,
        input  cfg_ready, freq_out, tick, active
    );

    modport slave (
        input  en, cfg_period, cfg_high, cfg_valid,
        output cfg_ready, freq_out, tick, active
    );
endinterface

// File: rtl/freq_generator.sv
// Period/high-time programmable wave generator with shadowed config that only
// takes effect on period boundaries, and a graceful stop at the end of a period.
//
// state | meaning
// IDLE  | outputs low; pending shadow config is promoted to active
// RUN   | counting 0..period-1, driving freq_out/tick
import freq_generator_pkg::*;

module freq_generator #(
    parameter int CNTR_SIZE  = 10,
    parameter int MIN_PERIOD = MIN_PERIOD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    freq_generator_if.slave  bus
);

    localparam logic [CNTR_SIZE-1:0] ONE   = CNTR_SIZE'(1);
    localparam logic [CNTR_SIZE-1:0] ZERO  = '0;
    localparam logic [CNTR_SIZE-1:0] MIN_P = CNTR_SIZE'(MIN_PERIOD);

    state_t               state, state_n;
    logic [CNTR_SIZE-1:0] cnt, cnt_n;
    logic                 pending, pending_n;
    logic [CNTR_SIZE-1:0] sh_period, sh_period_n;
    logic [CNTR_SIZE-1:0] sh_high, sh_high_n;
    logic                 active_valid, active_valid_n;
    logic [CNTR_SIZE-1:0] act_period, act_period_n;
    logic [CNTR_SIZE-1:0] act_high, act_high_n;
    logic                 freq_q, freq_n;
    logic                 tick_q, tick_n;
    logic                 active_q, active_n;
    logic                 ready_q, ready_n;

    logic                 xfer;
    logic                 wrap;
    logic [CNTR_SIZE-1:0] cnt_inc;
    logic [CNTR_SIZE-1:0] san_period;
    logic [CNTR_SIZE-1:0] san_high;
    logic [CNTR_SIZE-1:0] high_eff;

    always_comb begin
        san_period = (bus.cfg_period < MIN_P) ? MIN_P : bus.cfg_period;
        san_high   = (bus.cfg_high >= san_period) ? (san_period - ONE) : bus.cfg_high;
    end

    assign xfer    = bus.cfg_valid && !pending;
    assign wrap    = (cnt == (act_period - ONE));
    assign cnt_inc = cnt + ONE;
    // Whatever config will be active after this edge: a pending shadow wins.
    assign high_eff = pending ? sh_high : act_high;

    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        pending_n      = pending;
        sh_period_n    = sh_period;
        sh_high_n      = sh_high;
        active_valid_n = active_valid;
        act_period_n   = act_period;
        act_high_n     = act_high;
        freq_n         = 1'b0;
        tick_n         = 1'b0;
        active_n       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (pending) begin
                    act_period_n   = sh_period;
                    act_high_n     = sh_high;
                    active_valid_n = 1'b1;
                    pending_n      = 1'b0;
                end
                if (bus.en && active_valid) begin
                    state_n  = ST_RUN;
                    cnt_n    = ZERO;
                    tick_n   = 1'b1;
                    active_n = 1'b1;
                    freq_n   = (high_eff != ZERO);
                end
            end
            ST_RUN: begin
                active_n = 1'b1;
                if (wrap) begin
                    cnt_n = ZERO;
                    if (pending) begin
                        act_period_n = sh_period;
                        act_high_n   = sh_high;
                        pending_n    = 1'b0;
                    end
                    if (!bus.en) begin
                        state_n  = ST_IDLE;
                        active_n = 1'b0;
                    end else begin
                        tick_n = 1'b1;
                        freq_n = (high_eff != ZERO);
                    end
                end else begin
                    cnt_n  = cnt_inc;
                    freq_n = (cnt_inc < act_high);
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Only possible while pending is clear, so never collides with the loads above.
        if (xfer) begin
            pending_n   = 1'b1;
            sh_period_n = san_period;
            sh_high_n   = san_high;
        end

        ready_n = !pending_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            pending      <= 1'b0;
            sh_period    <= '0;
            sh_high      <= '0;
            active_valid <= 1'b0;
            act_period   <= '0;
            act_high     <= '0;
            freq_q       <= 1'b0;
            tick_q       <= 1'b0;
            active_q     <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            pending      <= pending_n;
            sh_period    <= sh_period_n;
            sh_high      <= sh_high_n;
            active_valid <= active_valid_n;
            act_period   <= act_period_n;
            act_high     <= act_high_n;
            freq_q       <= freq_n;
            tick_q       <= tick_n;
            active_q     <= active_n;
            ready_q      <= ready_n;
        end
    end

    assign bus.freq_out  = freq_q;
    assign bus.tick      = tick_q;
    assign bus.active    = active_q;
    assign bus.cfg_ready = ready_q;

endmodule

// File: tb/tb_freq_generator.sv
// Directed vector bench for freq_generator: checks {freq_out, tick, active, cfg_ready}.
module tb_freq_generator;

    localparam int W = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    freq_generator_if #(.CNTR_SIZE(W)) bus ();

    freq_generator #(.CNTR_SIZE(W), .MIN_PERIOD(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         en;
        logic         cv;
        logic [W-1:0] p;
        logic [W-1:0] h;
        logic [3:0]   exp;   // {freq_out, tick, active, cfg_ready}
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic add(input logic en, input logic cv, input int p, input int h,
                       input logic [3:0] exp);
        vec_t v;
        v.en = en; v.cv = cv; v.p = W'(p); v.h = W'(h); v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] exp);
        logic [3:0] act;
        act = {bus.freq_out, bus.tick, bus.active, bus.cfg_ready};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {freq,tick,active,ready}=%b expected %b at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.en = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_period = '0; bus.cfg_high = '0;
        step();
        step();
        rst = 1'b0;
        chk("reset_state", 4'b0001);
    endtask

    // Transfer, promote to active, start; leaves the DUT on cnt=0 of the first period.
    task automatic run_cfg(input int p, input int h);
        bus.cfg_period = W'(p); bus.cfg_high = W'(h);
        bus.cfg_valid = 1'b1; bus.en = 1'b1;
        step();
        bus.cfg_valid = 1'b0;
        chk("cfg_transfer", 4'b0000);
        step();
        chk("cfg_promote", 4'b0001);
        step();
    endtask

    initial begin
        bus.en = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_period = '0; bus.cfg_high = '0;

        // Start period 4/2, reconfigure to 6/3 mid-period, then offer 2/1 on a boundary edge.
        add(1,1,4,2,4'b0000); add(1,0,0,0,4'b0001); add(1,0,0,0,4'b1111);
        add(1,0,0,0,4'b1011); add(1,0,0,0,4'b0011); add(1,0,0,0,4'b0011);
        add(1,0,0,0,4'b1111); add(1,0,0,0,4'b1011);
        add(1,1,6,3,4'b0010); add(1,0,0,0,4'b0010);
        add(1,0,0,0,4'b1111); add(1,0,0,0,4'b1011); add(1,0,0,0,4'b1011);
        add(1,0,0,0,4'b0011); add(1,0,0,0,4'b0011); add(1,0,0,0,4'b0011);
        add(1,1,2,1,4'b1110);
        add(1,0,0,0,4'b1010); add(1,0,0,0,4'b1010); add(1,0,0,0,4'b0010);
        add(1,0,0,0,4'b0010); add(1,0,0,0,4'b0010);
        add(1,0,0,0,4'b1111); add(1,0,0,0,4'b0011); add(1,0,0,0,4'b1111);
        add(1,0,0,0,4'b0011);

        do_reset();
        foreach (vecs[i]) begin
            bus.en = vecs[i].en; bus.cfg_valid = vecs[i].cv;
            bus.cfg_period = vecs[i].p; bus.cfg_high = vecs[i].h;
            step();
            chk($sformatf("table[%0d]", i), vecs[i].exp);
        end
        bus.cfg_valid = 1'b0;

        // Sanitized 1/5 -> 2/1: toggles every cycle.
        do_reset();
        run_cfg(1, 5);
        chk("clamp_start", 4'b1111);
        for (int i = 1; i < 6; i++) begin
            step();
            chk($sformatf("clamp_cyc%0d", i), {(i % 2) == 0, (i % 2) == 0, 2'b11});
        end

        // high=0: freq_out stays low, tick keeps 5-cycle cadence.
        do_reset();
        run_cfg(5, 0);
        chk("high0_start", 4'b0111);
        for (int i = 1; i < 11; i++) begin
            step();
            chk($sformatf("high0_cyc%0d", i), {1'b0, (i % 5) == 0, 2'b11});
        end

        // Graceful stop: en dropped during cnt=1 of period 8.
        do_reset();
        run_cfg(8, 4);
        chk("stop_cnt0", 4'b1111);
        step();
        chk("stop_cnt1", 4'b1011);
        bus.en = 1'b0;
        for (int k = 2; k < 8; k++) begin
            step();
            chk($sformatf("stop_cnt%0d", k), {k < 4, 3'b011});
        end
        step();
        chk("stop_idle", 4'b0001);
        step();
        chk("stop_idle_hold", 4'b0001);

        // Restart from retained config, then cancel a stop at cnt=5.
        bus.en = 1'b1;
        step();
        chk("restart_cnt0", 4'b1111);
        step();
        chk("cancel_cnt1", 4'b1011);
        bus.en = 1'b0;
        for (int k = 2; k < 6; k++) begin
            step();
            chk($sformatf("cancel_cnt%0d", k), {k < 4, 3'b011});
        end
        bus.en = 1'b1;
        for (int k = 6; k < 8; k++) begin
            step();
            chk($sformatf("cancel_cnt%0d", k), 4'b0011);
        end
        step();
        chk("cancel_wrap", 4'b1111);
        step();
        chk("cancel_next", 4'b1011);

        // Reset mid-period: immediate abort, no restart until a new transfer.
        do_reset();
        run_cfg(4, 2);
        chk("rst_mid_cnt0", 4'b1111);
        step();
        step();
        chk("rst_mid_cnt2", 4'b0011);
        rst = 1'b1;
        step();
        chk("rst_mid_abort", 4'b0001);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("rst_no_restart%0d", i), 4'b0001);
        end
        run_cfg(4, 2);
        chk("rst_new_cfg_start", 4'b1111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
